// File: rtl/safety_output_ctrl.sv
// Dual-lane comparator output unit: complementary relay pairs gate relay_en, dual-lane heartbeats gate switch_en.
// Build option SAFETY_OUT_LATCH_EN: heartbeat faults latch until fault_clr instead of pulsing for one cycle.
module safety_output_ctrl #(
    parameter int CH         = 2,
    parameter int CNT_W      = 8,
    parameter int HB_MIN     = 4,
    parameter int HB_MAX     = 20,
    parameter int ARM_EDGES  = 4,
    parameter int RELAY_FILT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] relay_ctrl_a,
    input  logic [CH-1:0] relay_ctrl_b,
    input  logic [CH-1:0] sw_ctrl_a,
    input  logic [CH-1:0] sw_ctrl_b,
    input  logic          fault_clr,
    output logic [CH-1:0] relay_en,
    output logic [CH-1:0] switch_en,
    output logic [CH-1:0] fault
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ARM,
        ST_ON,
        ST_FAULT
    } state_e;

    logic [CH-1:0] relA1_q, relA2_q, relB1_q, relB2_q;
    logic [CH-1:0] swA1_q, swA2_q, swA3_q, swB1_q, swB2_q, swB3_q;

    // Two-flop synchronisers on every lane input; the third heartbeat stage is the edge-detect history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            relA1_q <= '0;
            relA2_q <= '0;
            relB1_q <= '0;
            relB2_q <= '0;
            swA1_q  <= '0;
            swA2_q  <= '0;
            swA3_q  <= '0;
            swB1_q  <= '0;
            swB2_q  <= '0;
            swB3_q  <= '0;
        end else begin
            relA1_q <= relay_ctrl_a;
            relA2_q <= relA1_q;
            relB1_q <= relay_ctrl_b;
            relB2_q <= relB1_q;
            swA1_q  <= sw_ctrl_a;
            swA2_q  <= swA1_q;
            swA3_q  <= swA2_q;
            swB1_q  <= sw_ctrl_b;
            swB2_q  <= swB1_q;
            swB3_q  <= swB2_q;
        end
    end

`ifndef SAFETY_OUT_LATCH_EN
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic             relGood;
        logic [3:0]       relCnt_q;
        logic             relEn_q;
        logic             edgeA, edgeB;
        logic             violA, violB;
        logic             goodA, goodB;
        logic [CNT_W-1:0] cntA_q, cntB_q;
        state_e           state_q, state_d;
        logic             seenA_q, seenA_d, seenB_q, seenB_d;
        logic [3:0]       goodCntA_q, goodCntA_d, goodCntB_q, goodCntB_d;

        assign relGood = relA2_q[i] ^ relB2_q[i];

        // Relay enable needs RELAY_FILT consecutive valid-pair cycles; any invalid cycle drops it at once.
        always_ff @(posedge clk) begin
            if (!rst) begin
                relCnt_q <= '0;
                relEn_q  <= 1'b0;
            end else begin
                if (!relGood)
                    relCnt_q <= '0;
                else if (relCnt_q != 4'hF)
                    relCnt_q <= relCnt_q + 4'd1;
                relEn_q <= relGood && (relCnt_q >= 4'(RELAY_FILT));
            end
        end

        assign edgeA = swA2_q[i] ^ swA3_q[i];
        assign edgeB = swB2_q[i] ^ swB3_q[i];
        assign violA = (edgeA && (cntA_q < CNT_W'(HB_MIN))) || (cntA_q == CNT_W'(HB_MAX));
        assign violB = (edgeB && (cntB_q < CNT_W'(HB_MIN))) || (cntB_q == CNT_W'(HB_MAX));
        assign goodA = edgeA && !violA;
        assign goodB = edgeB && !violB;

        // Interval counters run in every state so a timeout is visible the moment the FSM cares.
        always_ff @(posedge clk) begin
            if (!rst) begin
                cntA_q <= '0;
                cntB_q <= '0;
            end else begin
                if (edgeA)
                    cntA_q <= '0;
                else if (cntA_q != '1)
                    cntA_q <= cntA_q + 1'b1;
                if (edgeB)
                    cntB_q <= '0;
                else if (cntB_q != '1)
                    cntB_q <= cntB_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q    <= ST_OFF;
                seenA_q    <= 1'b0;
                seenB_q    <= 1'b0;
                goodCntA_q <= '0;
                goodCntB_q <= '0;
            end else begin
                state_q    <= state_d;
                seenA_q    <= seenA_d;
                seenB_q    <= seenB_d;
                goodCntA_q <= goodCntA_d;
                goodCntB_q <= goodCntB_d;
            end
        end

        // Arming counts only edges seen after entering ARM; the edges that woke OFF carry no interval history.
        always_comb begin
            state_d    = state_q;
            seenA_d    = seenA_q;
            seenB_d    = seenB_q;
            goodCntA_d = goodCntA_q;
            goodCntB_d = goodCntB_q;
            case (state_q)
                ST_OFF: begin
                    seenA_d    = seenA_q | edgeA;
                    seenB_d    = seenB_q | edgeB;
                    goodCntA_d = '0;
                    goodCntB_d = '0;
                    if (seenA_d && seenB_d) begin
                        state_d = ST_ARM;
                        seenA_d = 1'b0;
                        seenB_d = 1'b0;
                    end
                end
                ST_ARM: begin
                    if (violA || violB) begin
                        state_d = ST_FAULT;
                    end else begin
                        if (goodA && goodCntA_q != 4'hF)
                            goodCntA_d = goodCntA_q + 4'd1;
                        if (goodB && goodCntB_q != 4'hF)
                            goodCntB_d = goodCntB_q + 4'd1;
                        if ((goodCntA_q >= 4'(ARM_EDGES)) && (goodCntB_q >= 4'(ARM_EDGES)))
                            state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (violA || violB)
                        state_d = ST_FAULT;
                end
                ST_FAULT: begin
`ifdef SAFETY_OUT_LATCH_EN
                    if (fault_clr)
                        state_d = ST_OFF;
`else
                    state_d = ST_OFF;
`endif
                end
                default: state_d = ST_OFF;
            endcase
        end

        assign relay_en[i]  = relEn_q;
        assign switch_en[i] = (state_q == ST_ON);
        assign fault[i]     = (state_q == ST_FAULT);
    end

endmodule

// File: tb/tb_safety_output_ctrl.sv
// Directed bench for safety_output_ctrl: heartbeat arming, timeout and too-fast faults, relay filtering, reset.
// Follows the SAFETY_OUT_LATCH_EN build option of the design for fault-exit expectations.
module tb_safety_output_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] relA = '0, relB = '0, swA = '0, swB = '0;
    logic       faultClr = 1'b0;
    logic [1:0] relayEn, switchEn, faultO;

    int total = 0;
    int bad   = 0;
    int hbK   = 0;
    int perA  = 0;
    int perB  = 0;

    safety_output_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .relay_ctrl_a (relA),
        .relay_ctrl_b (relB),
        .sw_ctrl_a    (swA),
        .sw_ctrl_b    (swB),
        .fault_clr    (faultClr),
        .relay_en     (relayEn),
        .switch_en    (switchEn),
        .fault        (faultO)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b);
        relA = a;
        relB = b;
    endtask

    // Channel-0 heartbeat generator: each lane toggles when the running cycle index hits its period.
    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            if (perA != 0 && (hbK % perA) == 0) swA[0] = ~swA[0];
            if (perB != 0 && (hbK % perB) == 0) swB[0] = ~swB[0];
            hbK++;
            step(1);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        int h;
        // Reset values
        step(3);
        checkOutput("reset_relay", relayEn, 2'b00);
        checkOutput("reset_switch", switchEn, 2'b00);
        checkOutput("reset_fault", faultO, 2'b00);

        // Arming: edges at 0 (OFF->ARM at 3), good edges at 10..40 -> ON registered at cycle 44
        rst = 1'b1;
        hbK = 0; perA = 10; perB = 10;
        runCycles(43);
        checkOutput("arm_before_on", switchEn, 2'b00);
        checkOutput("arm_no_fault", faultO, 2'b00);
        runCycles(1);
        checkOutput("arm_on", switchEn, 2'b01);
        checkOutput("arm_relay_idle", relayEn, 2'b00);

        // Timeout: lane B last edge at 50, counter hits HB_MAX at 73, FAULT at 74
        runCycles(7);
        perB = 0;
        runCycles(22);
        checkOutput("timeout_still_on", switchEn, 2'b01);
        checkOutput("timeout_no_fault_yet", faultO, 2'b00);
        runCycles(1);
        checkOutput("timeout_switch_off", switchEn, 2'b00);
        checkOutput("timeout_fault", faultO, 2'b01);
        runCycles(1);
`ifdef SAFETY_OUT_LATCH_EN
        checkOutput("timeout_fault_held", faultO, 2'b01);
`else
        checkOutput("timeout_fault_pulse_end", faultO, 2'b00);
`endif
        perB = 10;

`ifdef SAFETY_OUT_LATCH_EN
        // Fault holds through healthy heartbeats until cleared, then re-arms
        runCycles(100);
        checkOutput("latch_hold_fault", faultO, 2'b01);
        checkOutput("latch_hold_switch", switchEn, 2'b00);
        faultClr = 1'b1;
        runCycles(1);
        faultClr = 1'b0;
        checkOutput("latch_cleared", faultO, 2'b00);
        runCycles(47);
        checkOutput("latch_rearm_pending", switchEn, 2'b00);
        runCycles(1);
        checkOutput("latch_rearm_on", switchEn, 2'b01);
`else
        // Automatic re-arm: ARM at 83, ON registered at 124
        runCycles(48);
        checkOutput("rearm_pending", switchEn, 2'b00);
        checkOutput("rearm_no_fault", faultO, 2'b00);
        runCycles(1);
        checkOutput("rearm_on", switchEn, 2'b01);
`endif

        // Too-fast: extra lane-A edge two cycles after a scheduled one
        h = hbK;
        runCycles(8);
        swA[0] = ~swA[0];
        runCycles(2);
        checkOutput("fast_still_on", switchEn, 2'b01);
        runCycles(1);
        checkOutput("fast_switch_off", switchEn, 2'b00);
        checkOutput("fast_fault", faultO, 2'b01);
        if (hbK != h + 11) $display("[TB] note: unexpected cycle index %0d", hbK);
        perA = 0; perB = 0;

        // Relay filter: ch1 valid pair, ch0 invalid (both 1)
        applyStimulus(2'b11, 2'b01);
        step(5);
        checkOutput("relay_filter_wait", relayEn, 2'b00);
        step(1);
        checkOutput("relay_rise", relayEn, 2'b10);
        applyStimulus(2'b11, 2'b11);
        step(2);
        checkOutput("relay_hold_sync", relayEn, 2'b10);
        step(1);
        checkOutput("relay_drop", relayEn, 2'b00);
        applyStimulus(2'b00, 2'b01);
        step(6);
        checkOutput("relay_ch0_b_only", relayEn, 2'b01);
        applyStimulus(2'b00, 2'b00);
        step(3);
        checkOutput("relay_idle", relayEn, 2'b00);
        applyStimulus(2'b10, 2'b00);
        step(2);
        applyStimulus(2'b10, 2'b10);
        for (int k = 0; k < 8; k++) begin
            step(1);
            checkOutput("relay_glitch", relayEn, 2'b00);
        end

        // Reset while ON with relays enabled
        swA = '0; swB = '0;
        applyStimulus(2'b00, 2'b00);
        rst = 1'b0;
        step(2);
        checkOutput("reset2_switch", switchEn, 2'b00);
        checkOutput("reset2_fault", faultO, 2'b00);
        rst = 1'b1;
        applyStimulus(2'b11, 2'b00);
        hbK = 0; perA = 10; perB = 10;
        runCycles(44);
        checkOutput("pre_reset_switch", switchEn, 2'b01);
        checkOutput("pre_reset_relay", relayEn, 2'b11);
        rst = 1'b0;
        step(1);
        checkOutput("midreset_relay", relayEn, 2'b00);
        checkOutput("midreset_switch", switchEn, 2'b00);
        checkOutput("midreset_fault", faultO, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
